// File: rtl/grf_mp_scoreboard_if.sv
// Register-file bus: decode read/issue signals plus write-back retire signals.
// master = pipeline side (decode + write-back), slave = register file.
interface grf_mp_scoreboard_if #(
    parameter int W     = 32,
    parameter int AW    = 5,
    parameter int NREAD = 2
);
    logic [NREAD*AW-1:0] RAddr;
    logic [NREAD*W-1:0]  RData;
    logic [NREAD-1:0]    RBusy;
    logic                WEn;
    logic [AW-1:0]       WAddr;
    logic [W-1:0]        WData;
    logic [31:0]         WPC;
    logic                IssueEn;
    logic [AW-1:0]       IssueAddr;
    logic                IssueReady;

    modport master (
        output RAddr, WEn, WAddr, WData, WPC, IssueEn, IssueAddr,
        input  RData, RBusy, IssueReady
    );

    modport slave (
        input  RAddr, WEn, WAddr, WData, WPC, IssueEn, IssueAddr,
        output RData, RBusy, IssueReady
    );
endinterface

// File: rtl/grf_mp_scoreboard.sv
// General register file with NREAD combinational read ports, one write-back port and a pending-write scoreboard.
// Reads and busy are zero-latency; writes/counters update on the edge; issue is refused when the counter is full.
module grf_mp_scoreboard #(
    parameter int W      = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    parameter int PW     = 2,
    parameter int TRACE  = 1
) (
    input  logic Clk,
    input  logic Reset,
    grf_mp_scoreboard_if.slave rf
);
    localparam logic [PW-1:0] CMAX = '1;

    logic [W-1:0]  mem [NREG] = '{default: '0};
    logic [PW-1:0] cnt [NREG] = '{default: '0};

    logic          dec;
    logic          inc;
    logic [PW-1:0] icnt_eff;

    assign dec = rf.WEn && (rf.WAddr != '0) && (cnt[rf.WAddr] != '0);

    // A retire in the same cycle frees a slot before the full check.
    assign icnt_eff      = cnt[rf.IssueAddr] - PW'(dec && (rf.WAddr == rf.IssueAddr));
    assign rf.IssueReady = (rf.IssueAddr == '0) || (icnt_eff != CMAX);
    assign inc           = rf.IssueEn && (rf.IssueAddr != '0) && rf.IssueReady;

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          hit;
        logic [PW-1:0] cnt_eff;

        assign ra      = rf.RAddr[k*AW +: AW];
        assign hit     = rf.WEn && (rf.WAddr == ra);
        assign cnt_eff = (BYPASS != 0) ? cnt[ra] - PW'(hit && (cnt[ra] != '0)) : cnt[ra];

        assign rf.RData[k*W +: W] = (ra == '0)              ? '0 :
                                    (BYPASS != 0 && hit)   ? rf.WData :
                                                             mem[ra];
        assign rf.RBusy[k] = (ra != '0) && (cnt_eff != '0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < NREG; r++) mem[r] <= '0;
        end else if (rf.WEn && rf.WAddr != '0) begin
            mem[rf.WAddr] <= rf.WData;
        end
    end

    // Entry 0 is never written outside reset, so it stays zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (inc && rf.IssueAddr == AW'(r) && !(dec && rf.WAddr == AW'(r)))
                    cnt[r] <= cnt[r] + 1'b1;
                else if (dec && rf.WAddr == AW'(r) && !(inc && rf.IssueAddr == AW'(r)))
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge Clk) begin
        if (TRACE != 0 && !Reset && rf.WEn && rf.WAddr != '0)
            $display("@%h: $%d <= %h", rf.WPC, rf.WAddr, rf.WData);
    end
`endif
endmodule

// File: tb/tb_grf_mp_scoreboard.sv
// Directed bench: a BYPASS=1 and a BYPASS=0 register file driven with identical stimulus.
module tb_grf_mp_scoreboard;
    logic        Clk;
    logic        Reset;
    logic [9:0]  raddr;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] wpc;
    logic        issue_en;
    logic [4:0]  issue_addr;

    int n_chk  = 0;
    int n_pass = 0;

    grf_mp_scoreboard_if #(.W(32), .AW(5), .NREAD(2)) ifa ();
    grf_mp_scoreboard_if #(.W(32), .AW(5), .NREAD(2)) ifb ();

    assign ifa.RAddr = raddr;      assign ifb.RAddr = raddr;
    assign ifa.WEn = wen;          assign ifb.WEn = wen;
    assign ifa.WAddr = waddr;      assign ifb.WAddr = waddr;
    assign ifa.WData = wdata;      assign ifb.WData = wdata;
    assign ifa.WPC = wpc;          assign ifb.WPC = wpc;
    assign ifa.IssueEn = issue_en; assign ifb.IssueEn = issue_en;
    assign ifa.IssueAddr = issue_addr;
    assign ifb.IssueAddr = issue_addr;

    grf_mp_scoreboard #(.BYPASS(1), .TRACE(1)) dut_a (.Clk(Clk), .Reset(Reset), .rf(ifa));
    grf_mp_scoreboard #(.BYPASS(0), .TRACE(0)) dut_b (.Clk(Clk), .Reset(Reset), .rf(ifb));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] p1, input logic [4:0] p0);
        raddr = {p1, p0};
        #1;
    endtask

    initial begin
        Reset = 1'b1; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0; wpc = '0;
        issue_en = 1'b0; issue_addr = '0;
        #1;
        chk("powerup_rdata", {32'h0, ifa.RData[31:0]}, 64'h0);
        step();
        Reset = 1'b0;
        rd(5'd5, 5'd5);
        chk("rst_rdata_a", ifa.RData, 64'h0);
        chk("rst_rbusy_a", ifa.RBusy, 2'b00);
        chk("rst_ready_a", ifa.IssueReady, 1'b1);

        // write $5
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; wpc = 32'h3000; #1;
        chk("t1_byp_a", ifa.RData, {32'hDEADBEEF, 32'hDEADBEEF});
        chk("t1_nobyp_b", ifb.RData, 64'h0);
        step();
        wen = 1'b0; #1;
        chk("t1_after_a", ifa.RData, {32'hDEADBEEF, 32'hDEADBEEF});
        chk("t1_after_b", ifb.RData, {32'hDEADBEEF, 32'hDEADBEEF});

        // write to $0
        rd(5'd0, 5'd0);
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; #1;
        chk("t2_r0_comb", ifa.RData, 64'h0);
        chk("t2_rbusy", ifa.RBusy, 2'b00);
        step();
        wen = 1'b0; #1;
        chk("t2_r0_after_a", ifa.RData, 64'h0);
        chk("t2_r0_after_b", ifb.RData, 64'h0);

        // bypass on $7
        rd(5'd7, 5'd5);
        wen = 1'b1; waddr = 5'd7; wdata = 32'h12345678; #1;
        chk("t3_byp_a", ifa.RData, {32'h12345678, 32'hDEADBEEF});
        chk("t3_old_b", ifb.RData, {32'h0, 32'hDEADBEEF});
        step();
        wen = 1'b0; #1;
        chk("t3_after_b", ifb.RData[63:32], 32'h12345678);

        // fill $3 scoreboard
        rd(5'd0, 5'd3);
        issue_en = 1'b1; issue_addr = 5'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t4_ready_%0d", i), ifa.IssueReady, 1'b1);
            step();
        end
        chk("t4_full_a", ifa.IssueReady, 1'b0);
        chk("t4_full_b", ifb.IssueReady, 1'b0);
        chk("t4_busy", {ifa.RBusy[0], ifb.RBusy[0]}, 2'b11);
        step();
        wen = 1'b1; waddr = 5'd3; wdata = 32'hAAAA0003; #1;
        chk("t4_retire_frees", ifa.IssueReady, 1'b1);
        chk("t4_busy_ret", ifa.RBusy[0], 1'b1);
        step();
        wen = 1'b0; #1;
        chk("t4_still_full", ifa.IssueReady, 1'b0);
        issue_en = 1'b0;
        wen = 1'b1;
        step();
        step();
        chk("t4_last_busy_a", ifa.RBusy[0], 1'b0);
        chk("t4_last_busy_b", ifb.RBusy[0], 1'b1);
        step();
        wen = 1'b0; #1;
        chk("t4_drained", {ifa.RBusy[0], ifb.RBusy[0]}, 2'b00);
        chk("t4_rdata", ifa.RData[31:0], 32'hAAAA0003);

        // issue then retire $9
        rd(5'd0, 5'd9);
        issue_en = 1'b1; issue_addr = 5'd9; #1;
        chk("t5_issue_nobusy", ifa.RBusy[0], 1'b0);
        step();
        issue_en = 1'b0; #1;
        chk("t5_busy", {ifa.RBusy[0], ifb.RBusy[0]}, 2'b11);
        wen = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D; #1;
        chk("t5_ret_a", {31'h0, ifa.RBusy[0], ifa.RData[31:0]}, {32'h0, 32'hCAFEF00D});
        chk("t5_ret_b", {31'h0, ifb.RBusy[0], ifb.RData[31:0]}, {32'h1, 32'h0});
        step();
        wen = 1'b0; #1;
        chk("t5_b_clear", ifb.RBusy[0], 1'b0);
        wen = 1'b1; wdata = 32'h11111111;
        step();
        wen = 1'b0; #1;
        chk("t5_spurious_data", ifa.RData[31:0], 32'h11111111);
        chk("t5_spurious_busy", ifa.RBusy[0], 1'b0);
        issue_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t5_no_underflow_%0d", i), ifa.IssueReady, 1'b1);
            step();
        end
        chk("t5_full", ifa.IssueReady, 1'b0);

        // issue to $0 never blocks nor marks busy
        issue_addr = 5'd0; #1;
        chk("t5_r0_ready", ifa.IssueReady, 1'b1);
        step();
        issue_en = 1'b0;
        rd(5'd0, 5'd0);
        chk("t5_r0_busy", ifa.RBusy, 2'b00);

        // reset overrides write and issue
        Reset = 1'b1; wen = 1'b1; waddr = 5'd5; wdata = 32'h55555555;
        issue_en = 1'b1; issue_addr = 5'd12;
        step();
        Reset = 1'b0; wen = 1'b0; issue_en = 1'b0; issue_addr = 5'd9;
        rd(5'd9, 5'd5);
        chk("t6_rdata_a", ifa.RData, 64'h0);
        chk("t6_rdata_b", ifb.RData, 64'h0);
        chk("t6_rbusy", {ifa.RBusy, ifb.RBusy}, 4'b0000);
        chk("t6_ready", ifa.IssueReady, 1'b1);
        rd(5'd12, 5'd7);
        chk("t6_rbusy12", ifa.RBusy, 2'b00);
        chk("t6_rdata7", ifa.RData, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
